// File: rtl/note_pkg.sv
// Shared key codes, FSM state type and default timing for the note_sequencer chart player.
package note_pkg;

  localparam logic [1:0] KEY_CLR = 2'b00;
  localparam logic [1:0] KEY_DO  = 2'b01;
  localparam logic [1:0] KEY_RE  = 2'b10;
  localparam logic [1:0] KEY_MI  = 2'b11;

  localparam int DEF_CHART_LEN      = 64;
  localparam int DEF_TICKS_PER_STEP = 25;  // 25 x 0.02 s = 0.5 s per step
  localparam int DEF_HOLD_TICKS     = 10;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT_TICK,
    HOLD,
    GAP,
    DONE
  } seq_state_t;

  function automatic logic [7:0] next_step(input logic [7:0] idx, input logic [7:0] last);
    return (idx == last) ? 8'd0 : idx + 8'd1;
  endfunction

endpackage

// File: rtl/note_sequencer_step_timer.sv
// Per-step tick counter: counts unpaused 0.02 s ticks and flags the hold and step boundaries.
module step_timer
  import note_pkg::*;
#(
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic tick002,
  input  logic pause,
  input  logic clear,
  output logic tick_en,
  output logic hold_end,
  output logic step_end
);

  localparam int CNT_W = $clog2(TICKS_PER_STEP);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick_en  = tick002 & ~pause;
  assign hold_end = tick_en && (tick_cnt == HOLD_LAST);
  assign step_end = tick_en && (tick_cnt == STEP_LAST);

  // The step boundary restarts the count, so it never passes TICKS_PER_STEP-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (tick_en) begin
      tick_cnt <= step_end ? '0 : tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Chart player: walks a note ROM and emits held-key / clear-code lane commands per step.
// Build option: NOTE_SEQ_LOOP_EN makes playback wrap to step 0 instead of ending in DONE.
//
// state     | meaning
// IDLE      | stopped, display cleared (wren=1)
// PRIME     | one cycle, latch step-0 note from ROM
// WAIT_TICK | armed, first unpaused tick starts step 0
// HOLD      | note code driven on key_address
// GAP       | clear code driven, next note prefetched
// DONE      | chart finished, display cleared, done=1
module note_sequencer
  import note_pkg::*;
#(
  parameter int CHART_LEN      = DEF_CHART_LEN,
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick002,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  output logic [7:0] chart_addr,
  input  logic [1:0] chart_data,
  output logic [1:0] key_address,
  output logic       wren,
  output logic       playing,
  output logic       done,
  output logic [7:0] step_index
);

`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_STEP = 8'(CHART_LEN - 1);

  seq_state_t state;
  logic [1:0] next_note;
  logic       tick_en;
  logic       hold_end;
  logic       step_end;
  logic       timer_clear;

  assign timer_clear = (state != HOLD) && (state != GAP);

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP),
    .HOLD_TICKS    (HOLD_TICKS)
  ) u_step_timer (
    .clock   (clock),
    .reset   (reset),
    .tick002 (tick002),
    .pause   (pause),
    .clear   (timer_clear),
    .tick_en (tick_en),
    .hold_end(hold_end),
    .step_end(step_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      next_note   <= KEY_CLR;
      key_address <= KEY_CLR;
      wren        <= 1'b1;
      playing     <= 1'b0;
      done        <= 1'b0;
      step_index  <= 8'd0;
      chart_addr  <= 8'd0;
    end else if (stop) begin
      state       <= IDLE;
      next_note   <= KEY_CLR;
      key_address <= KEY_CLR;
      wren        <= 1'b1;
      playing     <= 1'b0;
      done        <= 1'b0;
      step_index  <= 8'd0;
      chart_addr  <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= PRIME;
            key_address <= KEY_CLR;
            wren        <= 1'b0;
            playing     <= 1'b1;
            done        <= 1'b0;
            step_index  <= 8'd0;
            chart_addr  <= 8'd0;
          end
        end
        PRIME: begin
          if (!pause) begin
            next_note <= chart_data;
            state     <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick_en) begin
            state       <= HOLD;
            key_address <= next_note;
          end
        end
        HOLD: begin
          if (hold_end) begin
            state       <= GAP;
            key_address <= KEY_CLR;
            chart_addr  <= next_step(step_index, LAST_STEP);
          end
        end
        GAP: begin
          // Resampled every GAP cycle so the prefetch settles well before the step tick.
          next_note <= chart_data;
          if (step_end) begin
            if (step_index == LAST_STEP && !LOOP_EN) begin
              state       <= DONE;
              key_address <= KEY_CLR;
              wren        <= 1'b1;
              playing     <= 1'b0;
              done        <= 1'b1;
            end else begin
              state       <= HOLD;
              key_address <= next_note;
              step_index  <= next_step(step_index, LAST_STEP);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: table-driven chart vectors plus reset/pause/stop corner cases.
module tb_note_sequencer;

  localparam int CL = 3;
  localparam int TPS = 4;
  localparam int HT = 2;
  localparam int CHART_TICKS = CL * TPS;

`ifdef NOTE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       tick002;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] chart_addr;
  logic [1:0] chart_data;
  logic [1:0] key_address;
  logic       wren;
  logic       playing;
  logic       done;
  logic [7:0] step_index;

  logic [1:0] rom [4];

  typedef struct packed {
    logic [1:0] key;
    logic       wren;
    logic       playing;
    logic       done;
    logic [7:0] step;
    logic [7:0] addr;
  } exp_t;

  typedef struct {
    logic [1:0] rom  [3];
    logic [1:0] keys [12];
  } vec_t;

  localparam exp_t IDLE_EXP  = '{key: 2'b00, wren: 1'b1, playing: 1'b0, done: 1'b0, step: 8'd0, addr: 8'd0};
  localparam exp_t START_EXP = '{key: 2'b00, wren: 1'b0, playing: 1'b1, done: 1'b0, step: 8'd0, addr: 8'd0};
  localparam exp_t DONE_EXP  = '{key: 2'b00, wren: 1'b1, playing: 1'b0, done: 1'b1, step: 8'd2, addr: 8'd0};

  vec_t vec [3];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  note_sequencer #(
    .CHART_LEN     (CL),
    .TICKS_PER_STEP(TPS),
    .HOLD_TICKS    (HT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick002    (tick002),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .chart_addr (chart_addr),
    .chart_data (chart_data),
    .key_address(key_address),
    .wren       (wren),
    .playing    (playing),
    .done       (done),
    .step_index (step_index)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data reflects the address presented on the previous edge.
  always_ff @(posedge clock) chart_data <= rom[chart_addr[1:0]];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Expected outputs sampled after tick k of a playback started from step 0.
  function automatic exp_t expect_at(input int v, input int k);
    exp_t e;
    int   s;
    s = k % CHART_TICKS;
    if (k >= CHART_TICKS && !LOOP) begin
      e = DONE_EXP;
    end else begin
      e.key     = vec[v].keys[s];
      e.wren    = 1'b0;
      e.playing = 1'b1;
      e.done    = 1'b0;
      e.step    = 8'(s / TPS);
      e.addr    = (s < 2) ? 8'd0 : (s < 6) ? 8'd1 : (s < 10) ? 8'd2 : 8'd0;
    end
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_cmp++;
    if (key_address !== e.key || wren !== e.wren || playing !== e.playing ||
        done !== e.done || step_index !== e.step || chart_addr !== e.addr) begin
      n_err++;
      $display("FAIL %s: got key=%b wren=%b playing=%b done=%b step=%0d addr=%0d, want key=%b wren=%b playing=%b done=%b step=%0d addr=%0d",
               name, key_address, wren, playing, done, step_index, chart_addr,
               e.key, e.wren, e.playing, e.done, e.step, e.addr);
    end
  endtask

  task automatic check_next(input string name);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard, want a pending expectation", name);
    end else begin
      check(name, sb_q.pop_front());
    end
  endtask

  task automatic do_tick();
    repeat (4) @(negedge clock);
    tick002 = 1'b1;
    @(negedge clock);
    tick002 = 1'b0;
  endtask

  task automatic start_play(input int v);
    for (int i = 0; i < 3; i++) rom[i] = vec[v].rom[i];
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check($sformatf("v%0d_start", v), START_EXP);
    repeat (2) @(negedge clock);
  endtask

  task automatic play_ticks(input int v, input int k0, input int k1, input int glitch);
    for (int k = k0; k < k1; k++) sb_q.push_back(expect_at(v, k));
    for (int k = k0; k < k1; k++) begin
      if (k == glitch) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      do_tick();
      check_next($sformatf("v%0d_tick%0d", v, k));
    end
  endtask

  task automatic stop_check(input string name);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check(name, IDLE_EXP);
  endtask

  task automatic run_vector(input int v, input bit do_stop);
    start_play(v);
    play_ticks(v, 0, LOOP ? CHART_TICKS : CHART_TICKS + 1, -1);
    if (do_stop || LOOP) stop_check($sformatf("v%0d_stop", v));
  endtask

  initial begin
    vec[0].rom  = '{2'b01, 2'b10, 2'b11};
    vec[0].keys = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
    vec[1].rom  = '{2'b00, 2'b01, 2'b00};
    vec[1].keys = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[2].rom  = '{2'b11, 2'b00, 2'b10};
    vec[2].keys = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};

    for (int i = 0; i < 4; i++) rom[i] = 2'b00;
    reset   = 1'b1;
    tick002 = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    pause   = 1'b0;
    repeat (3) @(negedge clock);
    check("reset", IDLE_EXP);
    reset = 1'b0;
    @(negedge clock);

    // Table vectors; vector 2 starts from DONE when playback does not loop.
    run_vector(0, 1'b1);
    run_vector(1, 1'b0);
    run_vector(2, 1'b1);

    // Asynchronous reset while holding step 1.
    start_play(0);
    play_ticks(0, 0, 5, -1);
    #3 reset = 1'b1;
    #1 check("reset_mid_hold", IDLE_EXP);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Pause for three ticks during step 1 HOLD (tick count already 1).
    start_play(0);
    play_ticks(0, 0, 6, -1);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(expect_at(0, 5));
    for (int i = 0; i < 3; i++) begin
      do_tick();
      check_next($sformatf("pause_tick%0d", i));
    end
    pause = 1'b0;
    play_ticks(0, 6, LOOP ? CHART_TICKS : CHART_TICKS + 1, -1);
    stop_check("pause_stop");

    // start and stop together in GAP, then replay with a stray start mid-play.
    start_play(0);
    play_ticks(0, 0, 3, -1);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_gap", IDLE_EXP);
    do_tick();
    check("idle_tick", IDLE_EXP);
    start_play(0);
    play_ticks(0, 0, LOOP ? CHART_TICKS : CHART_TICKS + 1, 5);
    stop_check("replay_stop");

`ifdef NOTE_SEQ_LOOP_EN
    start_play(0);
    play_ticks(0, 0, 3 * CHART_TICKS + 1, -1);
    stop_check("loop_stop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
